display_scanner: RTL

//  Time-multiplexed 7-segment display driver for the calculator front panel.
//  It is the output-side counterpart of the keypad column scanner. It walks
//  one-hot digit enables across NUM_DIGITS digits and drives the segment code
//  for each digit's hex nibble.

---
 rtl/display_scanner_pkg.sv | 13 +
 rtl/display_scanner_hex_to_segments.sv | 11 +
 rtl/display_scanner.sv | 101 ++++++++++
 3 files changed

// File: rtl/display_scanner_pkg.sv
// display_scanner_pkg: segment code table, slot FSM encoding and output polarity helper
package display_scanner_pkg;
  typedef enum logic {BLANKING, DRIVE} slot_state_t;
  // Active-high {g,f,e,d,c,b,a} codes, nibble 0 in the low 7 bits.
  localparam logic [111:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  // XOR mask bit that turns an active-high level into the pin level.
  function automatic logic polarity_mask(input int active_low);
    return active_low != 0;
  endfunction
endpackage

// File: rtl/display_scanner_hex_to_segments.sv
// hex_to_segments: combinational hex nibble to active-high 7-segment code
//   nibble in  4  hex digit
//   code   out 7  {g,f,e,d,c,b,a}, active high
module hex_to_segments
  import display_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] code
);
  assign code = SEG_TABLE[int'(nibble)*7 +: 7];
endmodule

// File: rtl/display_scanner.sv
// display_scanner: double-buffered multiplexed 7-segment driver with per-slot blanking gap
//   clock, reset (async, active high)
//   value [4N]   hex nibbles, [3:0] = digit 0     dp [N]  decimal point per digit
//   load         strobe: capture value/dp/lz_suppress into staging
//   lz_suppress  blank leading zero digits        blank   force display off
//   digit_en [N] one-hot digit select              segments [7] {g,f,e,d,c,b,a}
//   seg_dp       decimal point of active digit     frame_done  pulse after last slot of a frame
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    lz_suppress,
  input  logic                    blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              segments,
  output logic                    seg_dp,
  output logic                    frame_done
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic INV = polarity_mask(ACTIVE_LOW);
  localparam slot_state_t RESET_STATE = BLANK_CYCLES > 0 ? BLANKING : DRIVE;
  logic [PW-1:0] prescaler, prescaler_next;
  logic [IW-1:0] idx, idx_next;
  slot_state_t state, state_next;
  logic [4*NUM_DIGITS-1:0] stage_value, shadow_value;
  logic [NUM_DIGITS-1:0] stage_dp, shadow_dp, zero_from, digit_en_d;
  logic stage_lz, shadow_lz, pending, wrap, tick, last, frame_end, z, drive_on, suppress, dp_d;
  logic [3:0] nibble;
  logic [6:0] code, seg_d;
  hex_to_segments u_hex (.nibble(nibble), .code(code));
  always_comb begin
    tick = prescaler == PW'(CLK_DIV - 1);
    last = idx == IW'(NUM_DIGITS - 1);
    frame_end = tick && last;
    prescaler_next = tick ? '0 : prescaler + 1'b1;
    idx_next = tick ? (last ? '0 : idx + 1'b1) : idx;
    state_next = prescaler_next < PW'(BLANK_CYCLES) ? BLANKING : DRIVE;
    // zero_from[i]: nibbles NUM_DIGITS-1..i of the shown frame are all zero
    zero_from = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z && shadow_value[4*i +: 4] == 4'd0;
      zero_from[i] = z;
    end
    nibble = shadow_value[{idx, 2'b00} +: 4];
    suppress = shadow_lz && idx != '0 && zero_from[idx];
    drive_on = state == DRIVE && !blank;
    digit_en_d = drive_on ? NUM_DIGITS'(1) << idx : '0;
    seg_d = drive_on && !suppress ? code : '0;
    dp_d = drive_on && shadow_dp[idx];
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      prescaler <= '0;
      idx <= '0;
      state <= RESET_STATE;
      stage_value <= '0;
      stage_dp <= '0;
      stage_lz <= 1'b0;
      shadow_value <= '0;
      shadow_dp <= '0;
      shadow_lz <= 1'b0;
      pending <= 1'b0;
      wrap <= 1'b0;
      frame_done <= 1'b0;
      digit_en <= {NUM_DIGITS{INV}};
      segments <= {7{INV}};
      seg_dp <= INV;
    end else begin
      prescaler <= prescaler_next;
      idx <= idx_next;
      state <= state_next;
      wrap <= frame_end;
      frame_done <= wrap;
      if (load) begin
        stage_value <= value;
        stage_dp <= dp;
        stage_lz <= lz_suppress;
      end
      // Old staging moves to shadow even when a new load lands on the same edge.
      if (frame_end && pending) begin
        shadow_value <= stage_value;
        shadow_dp <= stage_dp;
        shadow_lz <= stage_lz;
      end
      pending <= load || (pending && !frame_end);
      digit_en <= digit_en_d ^ {NUM_DIGITS{INV}};
      segments <= seg_d ^ {7{INV}};
      seg_dp <= dp_d ^ INV;
    end
endmodule
